// File: rtl/dcache_write_buffer.sv
// Write buffer between the dcache victim path and the memory write side.
// Dirty lines are queued in a small FIFO and drained to memory one at a time,
// in order. Buffered lines can be merged on re-eviction and are searchable by
// dcache-miss lookups so stale memory is never observed.

module dcache_write_buffer #(
    parameter int DEPTH            = 4,
    parameter int ADDR_SIZE        = 32,
    parameter int DATA_SIZE        = 32,
    parameter int PACKED_DATA_SIZE = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dcache_write_buffer_en,
    input  logic [ADDR_SIZE-1:0]        dcache_write_buffer_physical_addr,
    input  logic [PACKED_DATA_SIZE-1:0] dcache_write_buffer_data,
    output logic                        buffer_ready_for_dcache_write,
    output logic                        buffer_receive_dcache_write_ok,
    input  logic                        lookup_en,
    input  logic [ADDR_SIZE-1:0]        lookup_physical_addr,
    output logic                        buffer_hit_success,
    output logic [DATA_SIZE-1:0]        buffer_hit_data,
    output logic                        buffer_write_mem_en,
    output logic [ADDR_SIZE-1:0]        buffer_write_mem_addr,
    output logic [PACKED_DATA_SIZE-1:0] buffer_write_mem_data,
    input  logic                        mem_ready_for_buffer_write,
    input  logic                        mem_buffer_write_finish
);

    // state    | meaning
    // BUF_IDLE | nothing in flight; start a send when the FIFO holds a line
    // BUF_SEND | head line presented to memory, waiting for ready
    // BUF_WAIT | request accepted, waiting for the write-finish pulse
    typedef enum logic [1:0] {
        BUF_IDLE = 2'd0,
        BUF_SEND = 2'd1,
        BUF_WAIT = 2'd2
    } buf_state_t;

    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = $clog2(DEPTH + 1);
    localparam int LA_W       = ADDR_SIZE - 5;
    localparam int WORDS      = PACKED_DATA_SIZE / DATA_SIZE;
    localparam int WORD_SEL_W = $clog2(WORDS);

    buf_state_t                  r_state;
    buf_state_t                  w_state_next;
    logic                        r_valid [DEPTH];
    logic [LA_W-1:0]             r_addr  [DEPTH];
    logic [PACKED_DATA_SIZE-1:0] r_data  [DEPTH];
    logic [PTR_W-1:0]            r_head;
    logic [PTR_W-1:0]            r_tail;
    logic [CNT_W-1:0]            r_count;

    logic                        w_ready;
    logic                        w_accept;
    logic                        w_pop;
    logic                        w_alloc;
    logic                        w_head_busy;
    logic [LA_W-1:0]             w_in_la;
    logic [LA_W-1:0]             w_lk_la;
    logic                        w_merge;
    logic [PTR_W-1:0]            w_merge_idx;
    logic                        w_hit;
    logic [PTR_W-1:0]            w_hit_idx;
    logic [PTR_W-1:0]            w_scan_idx;
    logic [CNT_W-1:0]            w_count_next;
    logic [WORDS-1:0][DATA_SIZE-1:0] w_hit_words;
    logic [WORD_SEL_W-1:0]       w_word;
    logic                        w_unused;

    assign w_in_la     = dcache_write_buffer_physical_addr[ADDR_SIZE-1:5];
    assign w_lk_la     = lookup_physical_addr[ADDR_SIZE-1:5];
    assign w_word      = lookup_physical_addr[2 +: WORD_SEL_W];
    assign w_unused    = ^{dcache_write_buffer_physical_addr[4:0], lookup_physical_addr[1:0]};

    // Ready comes from the registered count only; it is forced low while in reset.
    assign w_ready     = !reset && (r_count < CNT_W'(DEPTH));
    assign w_accept    = dcache_write_buffer_en && w_ready;
    assign w_head_busy = (r_state != BUF_IDLE);
    assign w_pop       = (r_state == BUF_WAIT) && mem_buffer_write_finish;
    assign w_alloc     = w_accept && !w_merge;

    assign buffer_ready_for_dcache_write  = w_ready;
    assign buffer_receive_dcache_write_ok = w_accept;

    // Merge search: any valid entry with the same line, except an in-flight head.
    always_comb begin
        w_merge     = 1'b0;
        w_merge_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == w_in_la) &&
                !(w_head_busy && (PTR_W'(i) == r_head))) begin
                w_merge     = 1'b1;
                w_merge_idx = PTR_W'(i);
            end
        end
    end

    // Lookup: scan oldest to newest so the newest matching entry wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_scan_idx = r_head + PTR_W'(k);
            if (r_valid[w_scan_idx] && (r_addr[w_scan_idx] == w_lk_la)) begin
                w_hit     = 1'b1;
                w_hit_idx = w_scan_idx;
            end
        end
    end

    assign w_hit_words        = r_data[w_hit_idx];
    assign buffer_hit_success = lookup_en && w_hit;
    assign buffer_hit_data    = buffer_hit_success ? w_hit_words[w_word] : '0;

    // Net occupancy change: allocation and pop cancel out.
    always_comb begin
        w_count_next = r_count;
        case ({w_alloc, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_addr[i]  <= '0;
                r_data[i]  <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_accept) begin
                if (w_merge) begin
                    r_data[w_merge_idx] <= dcache_write_buffer_data;
                end else begin
                    r_valid[r_tail] <= 1'b1;
                    r_addr[r_tail]  <= w_in_la;
                    r_data[r_tail]  <= dcache_write_buffer_data;
                    r_tail          <= r_tail + PTR_W'(1);
                end
            end
            r_count <= w_count_next;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BUF_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Drain FSM next state and memory-side outputs.
    always_comb begin
        w_state_next          = r_state;
        buffer_write_mem_en   = 1'b0;
        buffer_write_mem_addr = '0;
        buffer_write_mem_data = '0;
        case (r_state)
            BUF_IDLE: begin
                if (r_count != '0) w_state_next = BUF_SEND;
            end
            BUF_SEND: begin
                buffer_write_mem_en   = 1'b1;
                buffer_write_mem_addr = {r_addr[r_head], 5'b0};
                buffer_write_mem_data = r_data[r_head];
                if (mem_ready_for_buffer_write) w_state_next = BUF_WAIT;
            end
            BUF_WAIT: begin
                if (mem_buffer_write_finish) w_state_next = BUF_IDLE;
            end
            default: w_state_next = BUF_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Self-checking bench for dcache_write_buffer: a queue-based line model,
// a per-cycle monitor and directed scenarios followed by random traffic.

module tb_dcache_write_buffer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [31:0]  paddr = '0;
    logic [255:0] wdata = '0;
    logic         ready;
    logic         ok;
    logic         lookup_en = 1'b0;
    logic [31:0]  lk_addr = '0;
    logic         hit;
    logic [31:0]  hit_data;
    logic         mem_en;
    logic [31:0]  mem_addr;
    logic [255:0] mem_data;
    logic         mem_ready = 1'b0;
    logic         finish = 1'b0;

    dcache_write_buffer dut (
        .clk                               (clk),
        .reset                             (reset),
        .dcache_write_buffer_en            (en),
        .dcache_write_buffer_physical_addr (paddr),
        .dcache_write_buffer_data          (wdata),
        .buffer_ready_for_dcache_write     (ready),
        .buffer_receive_dcache_write_ok    (ok),
        .lookup_en                         (lookup_en),
        .lookup_physical_addr              (lk_addr),
        .buffer_hit_success                (hit),
        .buffer_hit_data                   (hit_data),
        .buffer_write_mem_en               (mem_en),
        .buffer_write_mem_addr             (mem_addr),
        .buffer_write_mem_data             (mem_data),
        .mem_ready_for_buffer_write        (mem_ready),
        .mem_buffer_write_finish           (finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0]  la;
        logic [255:0] data;
    } line_t;

    // Reference model: pending lines oldest first; ph 0 idle, 1 presenting, 2 awaiting finish.
    line_t        mq[$];
    int           ph = 0;
    logic [31:0]  log_addr[$];
    logic [255:0] log_data[$];
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [255:0] pat(input logic [31:0] base);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = base * k;
        return d;
    endfunction

    function automatic logic [255:0] rnd_line();
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom;
        return d;
    endfunction

    // Model update at each clock edge from the inputs the DUT also samples.
    initial begin : model
        bit acc;
        bit pop;
        int mi;
        int first;
        line_t nl;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                ph = 0;
            end else begin
                acc   = en && (mq.size() < DEPTH);
                pop   = (ph == 2) && finish;
                mi    = -1;
                first = (ph != 0) ? 1 : 0;
                if (acc)
                    for (int j = first; j < mq.size(); j++)
                        if (mq[j].la == paddr[31:5]) mi = j;
                case (ph)
                    0: if (mq.size() > 0) ph = 1;
                    1: if (mem_ready) ph = 2;
                    2: if (finish) ph = 0;
                    default: ph = 0;
                endcase
                if (acc && mi >= 0) mq[mi].data = wdata;
                if (pop) void'(mq.pop_front());
                if (acc && mi < 0) begin
                    nl.la   = paddr[31:5];
                    nl.data = wdata;
                    mq.push_back(nl);
                end
            end
        end
    end

    // Monitor: compares every DUT output against the model away from the clock edge.
    initial begin : monitor
        logic         e_ready;
        logic         e_hit;
        logic [31:0]  e_hdata;
        logic [255:0] w;
        forever begin
            @(negedge clk);
            e_ready = !reset && (mq.size() < DEPTH);
            chk("ready", ready, e_ready);
            chk("ok", ok, e_ready && en);
            if (!reset && ph == 1 && mq.size() > 0) begin
                chk("mem_en", mem_en, 1'b1);
                chk("mem_addr", mem_addr, {mq[0].la, 5'b0});
                chk("mem_data", mem_data, mq[0].data);
                if (mem_ready) begin
                    log_addr.push_back(mem_addr);
                    log_data.push_back(mem_data);
                end
            end else begin
                chk("mem_en", mem_en, 1'b0);
                chk("mem_addr", mem_addr, 32'h0);
                chk("mem_data", mem_data, 256'h0);
            end
            e_hit = 1'b0;
            e_hdata = '0;
            if (lookup_en && !reset)
                for (int j = mq.size() - 1; j >= 0; j--)
                    if (!e_hit && mq[j].la == lk_addr[31:5]) begin
                        e_hit = 1'b1;
                        w = mq[j].data;
                        e_hdata = w[32*lk_addr[4:2] +: 32];
                    end
            chk("hit", hit, e_hit);
            chk("hit_data", hit_data, e_hdata);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        while (ph != p && n < 50) begin
            cyc();
            n++;
        end
        if (ph != p) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_phase: phase %0d required %0d", ph, p);
        end
    endtask

    task automatic drain();
        int n;
        en = 0;
        lookup_en = 0;
        mem_ready = 1;
        n = 0;
        while (!(mq.size() == 0 && ph == 0) && n < 200) begin
            finish = (ph == 2);
            cyc();
            finish = 0;
            n++;
        end
        if (!(mq.size() == 0 && ph == 0)) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: lines left %0d required 0", mq.size());
        end
    endtask

    task automatic put(input logic [31:0] a, input logic [255:0] d);
        en = 1;
        paddr = a;
        wdata = d;
        cyc();
        en = 0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] pool [6];
        pool = '{32'h0000_7000, 32'h0000_7020, 32'h0000_7040,
                 32'h0000_8000, 32'h0000_8020, 32'h0001_7000};

        // Reset state.
        en = 1;
        #3 chk("rst_ready", ready, 1'b0);
        chk("rst_ok", ok, 1'b0);
        en = 0;
        cyc(); cyc();
        reset = 0;
        #3 chk("post_rst_ready", ready, 1'b1);
        cyc();

        // T1: single line, hit, drain, miss after finish.
        en = 1; paddr = 32'h0000_1020; wdata = pat(32'h1111_1111); mem_ready = 1;
        #3 chk("t1_ok", ok, 1'b1);
        cyc();
        en = 0; lookup_en = 1; lk_addr = 32'h0000_1024;
        #3 chk("t1_hit", hit, 1'b1);
        chk("t1_hit_data", hit_data, 32'h1111_1111);
        chk("t1_en_n1", mem_en, 1'b0);
        cyc();
        lookup_en = 0;
        #3 chk("t1_en_n2", mem_en, 1'b1);
        chk("t1_addr", mem_addr, 32'h0000_1020);
        chk("t1_data", mem_data, pat(32'h1111_1111));
        cyc();
        finish = 1;
        cyc();
        finish = 0; lookup_en = 1; lk_addr = 32'h0000_1020;
        #3 chk("t1_miss", hit, 1'b0);
        cyc();
        lookup_en = 0;
        drain();

        // T2: fill, reject fifth, ready after pop, order preserved.
        log_addr.delete(); log_data.delete();
        mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            en = 1; paddr = 32'h0000_2000 + 32'(i) * 32'h20; wdata = rnd_line();
            #3 chk("t2_ok", ok, 1'b1);
            cyc();
        end
        en = 1; paddr = 32'h0000_2100; wdata = rnd_line();
        #3 chk("t2_full_ready", ready, 1'b0);
        chk("t2_full_ok", ok, 1'b0);
        cyc();
        en = 0; lookup_en = 1; lk_addr = 32'h0000_2100;
        #3 chk("t2_fifth_miss", hit, 1'b0);
        lookup_en = 0;
        mem_ready = 1;
        cyc();
        finish = 1;
        #3 chk("t2_ready_before_pop", ready, 1'b0);
        cyc();
        finish = 0;
        #3 chk("t2_ready_after_pop", ready, 1'b1);
        drain();
        chk("t2_drains", 256'(log_addr.size()), 256'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++)
            chk("t2_order", log_addr[i], 32'h0000_2000 + 32'(i) * 32'h20);

        // T3: merge into a non-head entry while head is in flight.
        log_addr.delete(); log_data.delete();
        mem_ready = 1;
        put(32'h0000_3000, pat(32'h0000_0003));
        wait_phase(2);
        put(32'h0000_3040, pat(32'h0000_0101));
        put(32'h0000_3040, pat(32'h0000_0202));
        put(32'h0000_3080, pat(32'h0000_0303));
        lookup_en = 1; lk_addr = 32'h0000_3048;
        #3 chk("t3_ready_count3", ready, 1'b1);
        chk("t3_hit", hit, 1'b1);
        chk("t3_hit_data", hit_data, 32'h0000_0404);
        cyc();
        drain();
        chk("t3_drains", 256'(log_addr.size()), 256'd3);
        if (log_addr.size() == 3) begin
            chk("t3_b_addr", log_addr[1], 32'h0000_3040);
            chk("t3_b_data", log_data[1], pat(32'h0000_0202));
        end

        // T4: re-evicting the in-flight head allocates a fresh entry.
        log_addr.delete(); log_data.delete();
        mem_ready = 1;
        put(32'h0000_4000, pat(32'h0000_0005));
        wait_phase(2);
        put(32'h0000_4000, pat(32'h0000_0007));
        lookup_en = 1; lk_addr = 32'h0000_4004;
        #3 chk("t4_hit", hit, 1'b1);
        chk("t4_hit_data", hit_data, 32'h0000_0007);
        cyc();
        drain();
        chk("t4_drains", 256'(log_addr.size()), 256'd2);
        if (log_addr.size() == 2) begin
            chk("t4_second_addr", log_addr[1], 32'h0000_4000);
            chk("t4_second_data", log_data[1], pat(32'h0000_0007));
        end

        // T5: reset while presenting a line to memory.
        mem_ready = 0;
        put(32'h0000_5000, pat(32'h0000_0009));
        wait_phase(1);
        reset = 1; en = 1; paddr = 32'h0000_5020; lookup_en = 1; lk_addr = 32'h0000_5000;
        #3 chk("t5_ready", ready, 1'b0);
        chk("t5_ok", ok, 1'b0);
        chk("t5_mem_en", mem_en, 1'b0);
        chk("t5_mem_addr", mem_addr, 32'h0);
        chk("t5_mem_data", mem_data, 256'h0);
        chk("t5_hit", hit, 1'b0);
        chk("t5_hit_data", hit_data, 32'h0);
        cyc();
        reset = 0; en = 0; mem_ready = 1;
        #3 chk("t5_ready_back", ready, 1'b1);
        chk("t5_miss", hit, 1'b0);
        lookup_en = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t5_no_en", mem_en, 1'b0);
        end
        put(32'h0000_5040, pat(32'h0000_000B));
        drain();

        // T6: enqueue and pop together at DEPTH-1.
        mem_ready = 1;
        put(32'h0000_6000, rnd_line());
        put(32'h0000_6020, rnd_line());
        put(32'h0000_6040, rnd_line());
        wait_phase(2);
        #3 chk("t6_ready_pre", ready, 1'b1);
        en = 1; paddr = 32'h0000_6060; wdata = rnd_line(); finish = 1;
        #1 chk("t6_ok", ok, 1'b1);
        cyc();
        en = 0; finish = 0;
        #3 chk("t6_ready_post", ready, 1'b1);
        put(32'h0000_6080, rnd_line());
        #3 chk("t6_ready_full", ready, 1'b0);
        drain();

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            en        = ($urandom % 2) == 0;
            paddr     = pool[$urandom % 6] | 32'($urandom % 32);
            wdata     = rnd_line();
            lookup_en = ($urandom % 2) == 0;
            lk_addr   = pool[$urandom % 6] | 32'($urandom % 32);
            mem_ready = ($urandom % 3) != 0;
            finish    = (ph == 2) && (($urandom % 3) == 0);
            cyc();
        end
        finish = 0;
        drain();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
